rdma_sfifo_wr_arb: RTL and testbench

Packet-atomic round-robin write arbiter that lets N_REQ upstream requesters share one single-clock FIFO instance (scfifo-based sfifo wrapper).
- Each requester presents beats with valid/ready/last.
- The arbiter locks a grant for a whole packet and tags each beat with its source ID.
- It drives the FIFO write port from a registered stage, throttled by the FIFO almost_full.
- It sits between per-queue RDMA producers and the shared sfifo.

---
 rtl/rdma_arb_pkg.sv | 38 +++
 rtl/rdma_rr_picker.sv | 29 ++
 rtl/rdma_sfifo_wr_arb.sv | 126 ++++++++++++
 tb/tb_rdma_sfifo_wr_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_arb_pkg.sv
// Shared types and the round-robin scan helper for the sfifo write arbiter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package rdma_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int PTR_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // First set bit of req, scanning ptr+1, ptr+2, ... modulo n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PTR_W-1:0]   ptr,
                                      input int                 n);
        pick_t            res;
        int               c;
        logic [PTR_W-1:0] pos;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            c   = (int'(ptr) + k) % n;
            pos = PTR_W'(c);
            if ((k <= n) && !res.found && req[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rdma_rr_picker.sv
// Round-robin winner select: first requester after i_ptr with its request set.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of i_req and i_ptr.
module rdma_rr_picker
    import rdma_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_found
);

    pick_t w_pick;
    logic  w_unused;

    // Rotate-and-scan lives in the package so the rule has a single definition.
    always_comb begin
        w_pick = rr_pick(MAX_REQ'(i_req), PTR_W'(i_ptr), N_REQ);
    end

    assign o_idx    = w_pick.idx[ID_W-1:0];
    assign o_found  = w_pick.found;
    // Upper index bits are always zero for N_REQ below MAX_REQ.
    assign w_unused = ^w_pick.idx;

endmodule

// File: rtl/rdma_sfifo_wr_arb.sv
// Packet-atomic round-robin arbiter feeding one shared sfifo write port, beats tagged with source ID.
// Latency: accepted beat appears on fifo_wr_en/fifo_din one cycle later; one IDLE bubble per packet.
// Backpressure: fifo_almost_full combinationally drops in_ready of the granted requester.
module rdma_sfifo_wr_arb
    import rdma_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    localparam int ID_W      = $clog2(N_REQ),
    localparam int FIFO_W    = DATA_WIDTH + 1 + ID_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [N_REQ-1:0]            in_valid,
    input  logic [N_REQ-1:0]            in_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]            in_ready,
    output logic                        fifo_wr_en,
    output logic [FIFO_W-1:0]           fifo_din,
    input  logic                        fifo_almost_full,
    input  logic                        fifo_overflow,
    output logic                        busy,
    output logic [ID_W-1:0]             cur_id,
    output logic                        err_overflow
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ID_W-1:0]       r_cur_id;
    logic [ID_W-1:0]       w_cur_id_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       w_pick_idx;
    logic                  w_pick_found;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_wr_en;
    logic [FIFO_W-1:0]     r_din;
    logic                  r_err;

    rdma_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_req   (in_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_last   = in_last[r_cur_id];
    assign w_data   = in_data[int'(r_cur_id)*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept = (r_state == BURST) & in_valid[r_cur_id] & ~fifo_almost_full;

    // Only the granted requester may see ready, and only while the FIFO has headroom.
    always_comb begin
        in_ready = '0;
        if (r_state == BURST) begin
            in_ready[r_cur_id] = ~fifo_almost_full;
        end
    end

    // Grant is taken in IDLE only; BURST ignores en so a packet is never cut short.
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_id_nxt = r_cur_id;
        case (r_state)
            IDLE: begin
                if (en && w_pick_found) begin
                    w_state_nxt  = BURST;
                    w_cur_id_nxt = w_pick_idx;
                end
            end
            BURST: begin
                if (w_accept && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, grant and round-robin pointer; pointer moves only when a packet ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cur_id <= '0;
            r_rr_ptr <= ID_W'(N_REQ - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_cur_id <= w_cur_id_nxt;
            if (w_accept && w_last) begin
                r_rr_ptr <= r_cur_id;
            end
        end
    end

    // Registered FIFO write stage; din holds its last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en <= 1'b0;
            r_din   <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_din <= {r_cur_id, w_last, w_data};
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (fifo_overflow) begin
            r_err <= 1'b1;
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_din     = r_din;
    assign busy         = (r_state == BURST);
    assign cur_id       = r_cur_id;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_rdma_sfifo_wr_arb.sv
module tb_rdma_sfifo_wr_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_last = '0;
    logic [127:0] in_data = '0;
    logic [3:0]   in_ready;
    logic         fifo_wr_en;
    logic [34:0]  fifo_din;
    logic         fifo_almost_full = 1'b0;
    logic         fifo_overflow = 1'b0;
    logic         busy;
    logic [1:0]   cur_id;
    logic         err_overflow;

    logic [2:0]   v3 = '0;
    logic [2:0]   l3 = '0;
    logic [95:0]  d3 = '0;
    logic [2:0]   rdy3;
    logic         wr3;
    logic [34:0]  din3;
    logic         af3 = 1'b0;
    logic         ov3 = 1'b0;
    logic         busy3;
    logic [1:0]   cur3;
    logic         err3;

    int n_checks = 0;
    int n_fail   = 0;

    int nbeats[4];
    int bi[4];
    int pk[4];
    int left[4];

    logic [3:0]  acc_v;
    logic [34:0] wq[$];
    logic        busy_h[$];
    logic        wr_h[$];
    logic [3:0]  rdy_h[$];
    logic [1:0]  cur_h[$];

    always #5 clk = ~clk;

    rdma_sfifo_wr_arb #(.N_REQ(4), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_din         (fifo_din),
        .fifo_almost_full (fifo_almost_full),
        .fifo_overflow    (fifo_overflow),
        .busy             (busy),
        .cur_id           (cur_id),
        .err_overflow     (err_overflow)
    );

    rdma_sfifo_wr_arb #(.N_REQ(3), .DATA_WIDTH(32)) dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .in_valid         (v3),
        .in_last          (l3),
        .in_data          (d3),
        .in_ready         (rdy3),
        .fifo_wr_en       (wr3),
        .fifo_din         (din3),
        .fifo_almost_full (af3),
        .fifo_overflow    (ov3),
        .busy             (busy3),
        .cur_id           (cur3),
        .err_overflow     (err3)
    );

    function automatic logic [31:0] mkdata(input int r, input int p, input int b);
        return {8'(r), 8'(p), 16'(b)};
    endfunction

    function automatic logic [34:0] mkword(input int id, input int last, input int p, input int b);
        return {2'(id), 1'(last), mkdata(id, p, b)};
    endfunction

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            if (left[r] > 0) begin
                in_valid[r]          = 1'b1;
                in_last[r]           = (bi[r] == nbeats[r] - 1);
                in_data[r*32 +: 32]  = mkdata(r, pk[r], bi[r]);
            end else begin
                in_valid[r] = 1'b0;
                in_last[r]  = 1'b0;
            end
        end
    endtask

    // Sample one cycle at the falling edge, then advance requesters that were accepted.
    task automatic cycle();
        @(negedge clk);
        acc_v = in_valid & in_ready;
        busy_h.push_back(busy);
        wr_h.push_back(fifo_wr_en);
        rdy_h.push_back(in_ready);
        cur_h.push_back(cur_id);
        if (fifo_wr_en) wq.push_back(fifo_din);
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            if (acc_v[r]) begin
                bi[r]++;
                if (bi[r] == nbeats[r]) begin
                    bi[r] = 0;
                    pk[r]++;
                    left[r]--;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        en               = 1'b1;
        fifo_almost_full = 1'b0;
        fifo_overflow    = 1'b0;
        for (int r = 0; r < 4; r++) begin
            left[r] = 0; bi[r] = 0; pk[r] = 0; nbeats[r] = 1;
        end
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wq.delete(); busy_h.delete(); wr_h.delete(); rdy_h.delete(); cur_h.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, fifo_wr_en, cur_id, err_overflow, in_ready} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b wr=%b id=%0d err=%b rdy=%b, want all 0",
                     busy, fifo_wr_en, cur_id, err_overflow, in_ready);
        end
        n_checks++;
        if (fifo_din !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_din: got %h want 0", fifo_din);
        end
        do_reset();
    endtask

    task automatic test_single_packet();
        bit   exp_wr[7]   = '{0, 0, 1, 1, 1, 0, 0};
        bit   exp_busy[7] = '{0, 1, 1, 1, 0, 0, 0};
        logic [3:0] exp_rdy[7] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        do_reset();
        nbeats[0] = 3; left[0] = 1;
        drive();
        for (int c = 0; c < 7; c++) cycle();
        for (int c = 0; c < 7; c++) begin
            n_checks++;
            if (wr_h[c] !== exp_wr[c] || busy_h[c] !== exp_busy[c] || rdy_h[c] !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL single_timing c%0d: got wr=%b busy=%b rdy=%b want wr=%b busy=%b rdy=%b",
                         c, wr_h[c], busy_h[c], rdy_h[c], exp_wr[c], exp_busy[c], exp_rdy[c]);
            end
        end
        n_checks++;
        if (wq.size() != 3) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes want 3", wq.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                n_checks++;
                if (wq[b] !== mkword(0, (b == 2) ? 1 : 0, 0, b)) begin
                    n_fail++;
                    $display("FAIL single_din beat%0d: got %h want %h", b, wq[b], mkword(0, (b == 2) ? 1 : 0, 0, b));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int  bad_onehot = 0;
        bit  exp_wr;
        int  j;
        do_reset();
        for (int r = 0; r < 4; r++) begin nbeats[r] = 2; left[r] = 2; end
        drive();
        for (int c = 0; c < 30; c++) cycle();
        for (int c = 0; c < 30; c++) begin
            exp_wr = (c >= 2) && (c < 26) && (((c - 2) % 3) != 2);
            n_checks++;
            if (wr_h[c] !== exp_wr) begin
                n_fail++;
                $display("FAIL rr_wr_timing c%0d: got %b want %b", c, wr_h[c], exp_wr);
            end
            if ($countones(rdy_h[c]) > 1) bad_onehot++;
        end
        n_checks++;
        if (bad_onehot != 0) begin
            n_fail++;
            $display("FAIL rr_ready_onehot: got %0d multi-ready cycles want 0", bad_onehot);
        end
        n_checks++;
        if (wq.size() != 16) begin
            n_fail++;
            $display("FAIL rr_count: got %0d writes want 16", wq.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                j = k / 2;
                n_checks++;
                if (wq[k] !== mkword(j % 4, k % 2, j / 4, k % 2)) begin
                    n_fail++;
                    $display("FAIL rr_order write%0d: got %h want %h", k, wq[k], mkword(j % 4, k % 2, j / 4, k % 2));
                end
            end
        end
    endtask

    task automatic test_almost_full();
        bit         exp_wr[9]  = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
        logic [3:0] exp_rdy[9] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        do_reset();
        nbeats[0] = 4; left[0] = 1;
        drive();
        cycle();
        cycle();
        fifo_almost_full = 1'b1;
        cycle();
        fifo_almost_full = 1'b0;
        for (int c = 0; c < 6; c++) cycle();
        for (int c = 0; c < 9; c++) begin
            n_checks++;
            if (wr_h[c] !== exp_wr[c] || rdy_h[c] !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL af_timing c%0d: got wr=%b rdy=%b want wr=%b rdy=%b",
                         c, wr_h[c], rdy_h[c], exp_wr[c], exp_rdy[c]);
            end
        end
        n_checks++;
        if (wq.size() != 4) begin
            n_fail++;
            $display("FAIL af_count: got %0d writes want 4", wq.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                n_checks++;
                if (wq[b] !== mkword(0, (b == 3) ? 1 : 0, 0, b)) begin
                    n_fail++;
                    $display("FAIL af_din beat%0d: got %h want %h", b, wq[b], mkword(0, (b == 3) ? 1 : 0, 0, b));
                end
            end
        end
    endtask

    task automatic test_en_drop();
        int exp_id[5]   = '{2, 2, 2, 0, 1};
        int exp_last[5] = '{0, 0, 1, 1, 1};
        do_reset();
        nbeats[2] = 3; left[2] = 1;
        drive();
        cycle();
        en = 1'b0;
        nbeats[0] = 1; left[0] = 1;
        nbeats[1] = 1; left[1] = 1;
        drive();
        for (int c = 0; c < 8; c++) cycle();
        en = 1'b1;
        for (int c = 0; c < 6; c++) cycle();
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (busy_h[c] !== ((c <= 3) || (c == 10))) begin
                n_fail++;
                $display("FAIL en_busy c%0d: got %b want %b", c, busy_h[c], ((c <= 3) || (c == 10)));
            end
        end
        n_checks++;
        if (cur_h[10] !== 2'd0) begin
            n_fail++;
            $display("FAIL en_regrant_id: got %0d want 0", cur_h[10]);
        end
        n_checks++;
        if (wq.size() != 5) begin
            n_fail++;
            $display("FAIL en_count: got %0d writes want 5", wq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (wq[k][34:32] !== {2'(exp_id[k]), 1'(exp_last[k])}) begin
                    n_fail++;
                    $display("FAIL en_order write%0d: got id/last %b want id=%0d last=%0d",
                             k, wq[k][34:32], exp_id[k], exp_last[k]);
                end
            end
        end
    endtask

    task automatic test_overflow_reset();
        do_reset();
        fifo_overflow = 1'b1;
        cycle();
        fifo_overflow = 1'b0;
        n_checks++;
        if (err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %b want 1", err_overflow);
        end
        nbeats[1] = 4; left[1] = 1;
        drive();
        cycle();
        cycle();
        #1;
        n_checks++;
        if ({err_overflow, busy, fifo_wr_en, cur_id} !== 5'b11101) begin
            n_fail++;
            $display("FAIL ovf_midpkt: got err=%b busy=%b wr=%b id=%0d want err=1 busy=1 wr=1 id=1",
                     err_overflow, busy, fifo_wr_en, cur_id);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({err_overflow, busy, fifo_wr_en, cur_id, in_ready} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: got err=%b busy=%b wr=%b id=%0d rdy=%b want all 0",
                     err_overflow, busy, fifo_wr_en, cur_id, in_ready);
        end
        do_reset();
    endtask

    task automatic test_wrap_n3();
        logic [34:0] exp3;
        bit          exp_wr;
        bit          exp_busy;
        do_reset();
        d3[64 +: 32] = 32'hC0DE_0002;
        exp3 = {2'd2, 1'b1, d3[64 +: 32]};
        v3 = 3'b100;
        l3 = 3'b100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_wr   = (c >= 2) && ((c % 2) == 0);
            exp_busy = ((c % 2) == 1);
            n_checks++;
            if (wr3 !== exp_wr || busy3 !== exp_busy) begin
                n_fail++;
                $display("FAIL n3_timing c%0d: got wr=%b busy=%b want wr=%b busy=%b", c, wr3, busy3, exp_wr, exp_busy);
            end
            if (exp_wr) begin
                n_checks++;
                if (din3 !== exp3) begin
                    n_fail++;
                    $display("FAIL n3_din c%0d: got %h want %h", c, din3, exp3);
                end
            end
            @(posedge clk);
            #1;
        end
        v3 = 3'b000;
        l3 = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_almost_full();
        test_en_drop();
        test_overflow_reset();
        test_wrap_n3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
